display_mux_n: RTL and testbench

//  N-digit time-multiplexed 7-segment driver; successor to the fixed 5-digit mux.

---
 rtl/display_pkg.sv | 41 ++++
 rtl/seg7_decode.sv | 11 +
 rtl/display_mux_n.sv | 102 ++++++++++
 tb/tb_display_mux_n.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: 7-segment glyphs in {a,b,c,d,e,f,g,dp} order and the hex glyph lookup.
package display_pkg;
    localparam logic [7:0] SEG_0     = 8'b1111_1100;
    localparam logic [7:0] SEG_1     = 8'b0110_0000;
    localparam logic [7:0] SEG_2     = 8'b1101_1010;
    localparam logic [7:0] SEG_3     = 8'b1111_0010;
    localparam logic [7:0] SEG_4     = 8'b0110_0110;
    localparam logic [7:0] SEG_5     = 8'b1011_0110;
    localparam logic [7:0] SEG_6     = 8'b1011_1110;
    localparam logic [7:0] SEG_7     = 8'b1110_0000;
    localparam logic [7:0] SEG_8     = 8'b1111_1110;
    localparam logic [7:0] SEG_9     = 8'b1111_0110;
    localparam logic [7:0] SEG_A     = 8'b1110_1110;
    localparam logic [7:0] SEG_B     = 8'b0011_1110;
    localparam logic [7:0] SEG_C     = 8'b1001_1100;
    localparam logic [7:0] SEG_D     = 8'b0111_1010;
    localparam logic [7:0] SEG_E     = 8'b1001_1110;
    localparam logic [7:0] SEG_F     = 8'b1000_1110;
    localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'ha: return SEG_A;
            4'hb: return SEG_B;
            4'hc: return SEG_C;
            4'hd: return SEG_D;
            4'he: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: hex nibble plus decimal point to segment pattern; blank forces everything dark.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] segments
);
    assign segments = blank ? SEG_BLANK : (hex_to_seg(nibble) | {7'b0, dp});
endmodule

// File: rtl/display_mux_n.sv
// display_mux_n: N-digit time-multiplexed 7-segment driver with frame snapshot,
// leading-zero blanking, blink, PWM dimming and per-slot dead time.
module display_mux_n
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 5,
    parameter int SEL_CE_DIV   = 100_000,
    parameter int SEG_CLK_BITS = 8,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_BITS  = 4,
    parameter int BLINK_FRAMES = 100
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic                    seg_clk,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   cathodes,
    output logic                    frame_start
);
    localparam int SW = $clog2(SEL_CE_DIV);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SEL_CE_DIV - 1);
    localparam logic [SW-1:0] SLOT_LIT   = SW'(BLANK_CYCLES);
    localparam logic [DW-1:0] SEL_LAST   = DW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [SW-1:0]           slot;
    logic [DW-1:0]           sel;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic [SEG_CLK_BITS-1:0] div;
    logic [BRIGHT_BITS-1:0]  pwm;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blink;
    logic                    snap_lz;
    logic [BRIGHT_BITS-1:0]  snap_bright;
    logic                    slot_end;
    logic                    frame_end;
    logic                    lit;
    logic                    blank;
    logic [7:0]              seg_next;

    assign slot_end  = slot == SLOT_LAST;
    assign frame_end = slot_end && sel == SEL_LAST;
    assign seg_clk   = div[SEG_CLK_BITS-1];
    // A digit is a leading zero when it and every more significant nibble are zero.
    assign blank = (snap_lz && sel != '0 && (snap_digits >> (4 * sel)) == '0)
                || (blink_phase && snap_blink[sel]);
    assign lit = slot >= SLOT_LIT && (&snap_bright || pwm < snap_bright);

    seg7_decode u_decode (
        .nibble  (snap_digits[4*sel +: 4]),
        .dp      (snap_dp[sel]),
        .blank   (blank),
        .segments(seg_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot        <= '0;
            sel         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            div         <= '0;
            pwm         <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blink  <= '0;
            snap_lz     <= 1'b0;
            snap_bright <= '0;
            segments    <= '0;
            cathodes    <= '0;
            frame_start <= 1'b0;
        end else begin
            div  <= div + 1'b1;
            pwm  <= pwm + 1'b1;
            slot <= slot_end ? '0 : slot + 1'b1;
            if (slot_end)
                sel <= frame_end ? '0 : sel + 1'b1;
            if (frame_end) begin
                snap_digits <= digits;
                snap_dp     <= dp;
                snap_blink  <= blink_mask;
                snap_lz     <= lz_blank;
                snap_bright <= brightness;
                blink_cnt   <= blink_cnt == BLINK_LAST ? '0 : blink_cnt + 1'b1;
                if (blink_cnt == BLINK_LAST)
                    blink_phase <= ~blink_phase;
            end
            segments    <= seg_next;
            cathodes    <= lit ? NUM_DIGITS'(1) << sel : '0;
            frame_start <= sel == '0 && slot == '0;
        end
    end
endmodule

// File: tb/tb_display_mux_n.sv
// tb_display_mux_n: random and directed stimulus against a cycle-index reference model.
module tb_display_mux_n;
    localparam int N = 4, DIV = 8, SCB = 3, BLK = 2, BB = 2, BF = 2, FRAME = N * DIV;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [15:0]   digits = '0;
    logic [3:0]    dp = '0;
    logic [3:0]    blink_mask = '0;
    logic          lz_blank = 1'b0;
    logic [1:0]    brightness = '0;
    logic          seg_clk;
    logic [7:0]    segments;
    logic [3:0]    cathodes;
    logic          frame_start;

    int n_checks = 0;
    int n_pass = 0;
    int k = 0;
    logic [15:0] cur_dig, pend_dig;
    logic [3:0]  cur_dp, pend_dp, cur_blink, pend_blink;
    logic        cur_lz, pend_lz;
    logic [1:0]  cur_bright, pend_bright;
    logic [7:0]  seg_tab [16] = '{8'hfc, 8'h60, 8'hda, 8'hf2, 8'h66, 8'hb6, 8'hbe, 8'he0,
                                  8'hfe, 8'hf6, 8'hee, 8'h3e, 8'h9c, 8'h7a, 8'h9e, 8'h8e};

    always #5 clk = ~clk;

    display_mux_n #(
        .NUM_DIGITS(N), .SEL_CE_DIV(DIV), .SEG_CLK_BITS(SCB),
        .BLANK_CYCLES(BLK), .BRIGHT_BITS(BB), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .digits(digits), .dp(dp),
        .blink_mask(blink_mask), .lz_blank(lz_blank), .brightness(brightness),
        .seg_clk(seg_clk), .segments(segments), .cathodes(cathodes), .frame_start(frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        k = 0;
        {cur_dig, cur_dp, cur_blink, cur_lz, cur_bright} = '0;
        {pend_dig, pend_dp, pend_blink, pend_lz, pend_bright} = '0;
    endtask

    // Outputs seen after edge k describe cycle c = k-1 since reset release.
    task automatic step();
        int c, sel, slot, f, nib;
        logic blank, lead, lit;
        logic [7:0] exp_seg;
        @(posedge clk);
        k++;
        c = k - 1;
        if (c > 0 && c % FRAME == 0)
            {cur_dig, cur_dp, cur_blink, cur_lz, cur_bright} = {pend_dig, pend_dp, pend_blink, pend_lz, pend_bright};
        if (k % FRAME == 0)
            {pend_dig, pend_dp, pend_blink, pend_lz, pend_bright} = {digits, dp, blink_mask, lz_blank, brightness};
        sel  = (c / DIV) % N;
        slot = c % DIV;
        f    = c / FRAME;
        nib  = int'(cur_dig[4*sel +: 4]);
        lead = sel > 0;
        for (int j = sel; j < N; j++)
            if (cur_dig[4*j +: 4] != 4'h0) lead = 1'b0;
        blank   = (cur_lz && lead) || ((f / BF) % 2 == 1 && cur_blink[sel]);
        exp_seg = blank ? 8'h00 : (seg_tab[nib] | {7'b0, cur_dp[sel]});
        lit     = slot >= BLK && (cur_bright == 2'd3 || (c % 4) < int'(cur_bright));
        @(negedge clk);
        check($sformatf("seg c=%0d", c), 32'(segments), 32'(exp_seg));
        check($sformatf("cath c=%0d", c), 32'(cathodes), lit ? 32'(1) << sel : 32'd0);
        check($sformatf("fstart c=%0d", c), 32'(frame_start), 32'(c % FRAME == 0));
        check($sformatf("segclk k=%0d", k), 32'(seg_clk), 32'((k >> (SCB - 1)) & 1));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        for (int i = 0; i < 4; i++)
            d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        return d;
    endfunction

    initial begin
        model_reset();
        #22;
        check("reset seg", 32'(segments), 32'd0);
        check("reset cath", 32'(cathodes), 32'd0);
        check("reset fstart", 32'(frame_start), 32'd0);
        check("reset segclk", 32'(seg_clk), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        digits = 16'h1234; brightness = 2'd3;
        run(2 * FRAME);
        digits = 16'h00a0; lz_blank = 1'b1;
        run(2 * FRAME);
        lz_blank = 1'b0;
        run(2 * FRAME);
        dp = 4'b0010;
        run(2 * FRAME);
        dp = 4'b0000; blink_mask = 4'b0001; digits = 16'h5678;
        run(6 * FRAME);
        blink_mask = 4'b0000; brightness = 2'd1;
        run(2 * FRAME);
        brightness = 2'd0;
        run(2 * FRAME);
        for (int i = 0; i < 30 * FRAME; i++) begin
            step();
            if ($urandom_range(0, 7) == 0) begin
                digits     = rand_digits();
                dp         = 4'($urandom);
                blink_mask = 4'($urandom);
                lz_blank   = 1'($urandom);
                brightness = 2'($urandom);
            end
        end
        // Mid-frame reset while digit slot 2 is active.
        while ((k % FRAME) != 2 * DIV + 3) step();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst seg", 32'(segments), 32'd0);
        check("midrst cath", 32'(cathodes), 32'd0);
        check("midrst fstart", 32'(frame_start), 32'd0);
        check("midrst segclk", 32'(seg_clk), 32'd0);
        repeat (2) @(negedge clk);
        model_reset();
        digits = 16'h9abc; brightness = 2'd3;
        reset_n = 1'b1;
        run(3 * FRAME);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
